// File: rtl/aline_pkg.sv
// Shared types and default constants for the A-line ping-pong writer.
package aline_pkg;

    localparam int NSAMPLES_DEFAULT = 1170;
    localparam int DATA_W           = 14;
    localparam int ADDR_W           = 11;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        HANDOFF
    } state_e;

endpackage

// File: rtl/aline_pingpong_writer_sync_bit.sv
// Multi-flop synchroniser for one asynchronous single-bit input.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/aline_pingpong_writer.sv
// ADC-domain writer: captures one A-line per trigger into a ping-pong RAM bank
// and hands full banks to the readout domain via toggle handshakes.
module aline_pingpong_writer #(
    parameter int NSAMPLES    = aline_pkg::NSAMPLES_DEFAULT,
    parameter int ADDR_W      = aline_pkg::ADDR_W,
    parameter int DATA_W      = aline_pkg::DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              ADC_data_out_clk,
    input  logic              global_reset_n,
    input  logic              trigger_in,
    input  logic              enable,
    input  logic [DATA_W-1:0] adc_data,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              buf_ready_toggle,
    output logic              buf_bank,
    input  logic              buf_release_toggle,
    output logic              acq_busy,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic [15:0]       line_count
);

    import aline_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NSAMPLES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic              trig_dly_q, trig_dly_d;
    logic              rel_dly_q, rel_dly_d;
    logic              ready_tog_q, ready_tog_d;
    logic              buf_bank_q, buf_bank_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       line_count_q, line_count_d;

    logic              trig_sync, rel_sync;
    logic              trig_edge, rel_apply;
    logic [1:0]        rel_mask, set_mask, full_after_rel;

    sync_bit #(.STAGES(SYNC_STAGES)) u_trig_sync (
        .clk   (ADC_data_out_clk),
        .rst_n (global_reset_n),
        .d     (trigger_in),
        .q     (trig_sync)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_rel_sync (
        .clk   (ADC_data_out_clk),
        .rst_n (global_reset_n),
        .d     (buf_release_toggle),
        .q     (rel_sync)
    );

    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        trig_dly_d   = trig_sync;
        rel_dly_d    = rel_sync;
        s_d          = adc_data;
        state_d      = state_q;
        idx_d        = idx_q;
        wr_bank_d    = wr_bank_q;
        ready_tog_d  = ready_tog_q;
        buf_bank_d   = buf_bank_q;
        line_count_d = line_count_q;
        overrun_d    = overrun_clr ? 1'b0 : overrun_q;

        trig_edge = trig_sync & ~trig_dly_q;

        // A release with nothing full is spurious and must not move the pointer.
        rel_apply      = (rel_sync ^ rel_dly_q) && (bank_full_q != 2'b00);
        rel_mask       = rel_apply ? (2'b01 << rd_bank_q) : 2'b00;
        set_mask       = 2'b00;
        full_after_rel = bank_full_q & ~rel_mask;
        rd_bank_d      = rel_apply ? ~rd_bank_q : rd_bank_q;

        case (state_q)
            IDLE: begin
                if (trig_edge && enable) begin
                    if (full_after_rel[wr_bank_q]) begin
                        overrun_d = 1'b1;
                    end else begin
                        state_d = CAPTURE;
                        idx_d   = '0;
                    end
                end
            end
            CAPTURE: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = HANDOFF;
                end
            end
            HANDOFF: begin
                set_mask     = 2'b01 << wr_bank_q;
                buf_bank_d   = wr_bank_q;
                ready_tog_d  = ~ready_tog_q;
                line_count_d = line_count_q + 16'd1;
                wr_bank_d    = ~wr_bank_q;
                idx_d        = '0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A release hitting the bank being marked full on the same cycle wins.
        bank_full_d = (bank_full_q | set_mask) & ~rel_mask;
    end

    always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            bank_full_q  <= 2'b00;
            s_q          <= '0;
            trig_dly_q   <= 1'b0;
            rel_dly_q    <= 1'b0;
            ready_tog_q  <= 1'b0;
            buf_bank_q   <= 1'b0;
            overrun_q    <= 1'b0;
            line_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            bank_full_q  <= bank_full_d;
            s_q          <= s_d;
            trig_dly_q   <= trig_dly_d;
            rel_dly_q    <= rel_dly_d;
            ready_tog_q  <= ready_tog_d;
            buf_bank_q   <= buf_bank_d;
            overrun_q    <= overrun_d;
            line_count_q <= line_count_d;
        end
    end

    assign wr_en            = (state_q == CAPTURE);
    assign acq_busy         = (state_q == CAPTURE);
    assign wr_addr          = {wr_bank_q, idx_q};
    assign wr_data          = s_q;
    assign buf_ready_toggle = ready_tog_q;
    assign buf_bank         = buf_bank_q;
    assign overrun          = overrun_q;
    assign line_count       = line_count_q;

endmodule

// File: tb/tb_aline_pingpong_writer.sv
// Scoreboard bench for aline_pingpong_writer: stimulus queues expected writes
// and handoffs, a negedge monitor pops and compares them.
module tb_aline_pingpong_writer;

    localparam int NS = 1170;
    localparam int AW = 11;
    localparam int DW = 14;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          global_reset_n = 1'b0;
    logic          trigger_in = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          buf_release_toggle = 1'b0;
    logic          overrun_clr = 1'b0;
    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic [DW-1:0] wr_data;
    logic          buf_ready_toggle;
    logic          buf_bank;
    logic          acq_busy;
    logic          overrun;
    logic [15:0]   line_count;

    aline_pingpong_writer #(
        .NSAMPLES    (NS),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .ADC_data_out_clk   (clk),
        .global_reset_n     (global_reset_n),
        .trigger_in         (trigger_in),
        .enable             (enable),
        .adc_data           (adc_data),
        .wr_en              (wr_en),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .buf_ready_toggle   (buf_ready_toggle),
        .buf_bank           (buf_bank),
        .buf_release_toggle (buf_release_toggle),
        .acq_busy           (acq_busy),
        .overrun            (overrun),
        .overrun_clr        (overrun_clr),
        .line_count         (line_count)
    );

    typedef struct {
        logic [AW:0]   addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic        bank;
        logic [15:0] lc;
    } ho_t;

    wr_t         exp_wr[$];
    ho_t         exp_ho[$];
    int          checks = 0;
    int          failures = 0;
    logic        last_tog = 1'b0;
    logic [15:0] exp_lc = '0;

    initial forever #5 clk = ~clk;

    // Free-running ramp; each value is sampled at the following rising edge.
    initial forever begin
        @(negedge clk);
        adc_data = adc_data + DW'(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!global_reset_n) begin
            last_tog = 1'b0;
        end else begin
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 32'(wr_en), 32'd0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                    check("acq_busy_in_write", 32'(acq_busy), 32'd1);
                end
            end
            if (buf_ready_toggle !== last_tog) begin
                if (exp_ho.size() == 0) begin
                    check("unexpected_ready_toggle", 32'(buf_ready_toggle), 32'(last_tog));
                end else begin
                    ho_t h;
                    h = exp_ho.pop_front();
                    check("buf_bank", 32'(buf_bank), 32'(h.bank));
                    check("line_count_at_handoff", 32'(line_count), 32'(h.lc));
                end
                last_tog = buf_ready_toggle;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic trigger_pulse(input int hi);
        trigger_in = 1'b1;
        tick(hi);
        trigger_in = 1'b0;
    endtask

    // First write carries the ramp value sampled SS edges after the trigger rises.
    task automatic start_line(input logic bank, input int nwr, input bit handoff);
        logic [DW-1:0] base;
        base = adc_data + DW'(SS);
        for (int k = 0; k < nwr; k++) begin
            exp_wr.push_back('{addr: {bank, AW'(k)}, data: base + DW'(k)});
        end
        if (handoff) begin
            exp_lc = exp_lc + 16'd1;
            exp_ho.push_back('{bank: bank, lc: exp_lc});
        end
        trigger_pulse(5);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_ho.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) begin
            check("drain_timeout", 32'(exp_wr.size() + exp_ho.size()), 32'd0);
            exp_wr.delete();
            exp_ho.delete();
        end
        tick(4);
    endtask

    task automatic release_bank();
        buf_release_toggle = ~buf_release_toggle;
        tick(6);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_ready_tog"}, 32'(buf_ready_toggle), 32'd0);
        check({tag, "_buf_bank"}, 32'(buf_bank), 32'd0);
        check({tag, "_acq_busy"}, 32'(acq_busy), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_line_count"}, 32'(line_count), 32'd0);
    endtask

    initial begin
        tick(3);
        check_all_zero("reset");
        global_reset_n = 1'b1;
        enable = 1'b1;
        tick(3);

        // Line 1 into bank 0.
        start_line(1'b0, NS, 1'b1);
        drain(2000);
        check("t1_ready_tog", 32'(buf_ready_toggle), 32'd1);
        check("t1_buf_bank", 32'(buf_bank), 32'd0);
        check("t1_line_count", 32'(line_count), 32'd1);

        // Line 2 into bank 1, then both banks full.
        start_line(1'b1, NS, 1'b1);
        drain(2000);
        check("t2_overrun_before", 32'(overrun), 32'd0);
        trigger_pulse(5);
        tick(4);
        check("t2_overrun_set", 32'(overrun), 32'd1);
        check("t2_busy_idle", 32'(acq_busy), 32'd0);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        tick(1);
        check("t2_overrun_clr", 32'(overrun), 32'd0);

        // Release frees bank 0; bank 1 still pending so the next trigger overruns.
        release_bank();
        start_line(1'b0, NS, 1'b1);
        drain(2000);
        trigger_pulse(5);
        tick(4);
        check("t3_overrun_set", 32'(overrun), 32'd1);
        check("t3_line_count", 32'(line_count), 32'd3);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        release_bank();
        release_bank();
        check("t3_overrun_clr", 32'(overrun), 32'd0);

        // Re-trigger around idx 500 must be ignored; wr_bank is now 1.
        start_line(1'b1, NS, 1'b1);
        tick(495);
        trigger_pulse(3);
        drain(2000);
        check("t4_overrun", 32'(overrun), 32'd0);
        check("t4_line_count", 32'(line_count), 32'd4);
        check("t4_buf_bank", 32'(buf_bank), 32'd1);
        release_bank();

        // Reset mid-capture after the write at idx 299 in bank 0.
        start_line(1'b0, 300, 1'b0);
        begin
            int n;
            n = 0;
            while (exp_wr.size() != 0 && n < 1000) begin
                tick(1);
                n++;
            end
            check("t5_reach_idx", 32'(exp_wr.size()), 32'd0);
            exp_wr.delete();
        end
        global_reset_n = 1'b0;
        buf_release_toggle = 1'b0;
        #1;
        check_all_zero("midreset");
        tick(3);
        global_reset_n = 1'b1;
        exp_lc = '0;
        tick(3);

        // Disabled triggers are ignored entirely.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            trigger_pulse(4);
            tick(4);
        end
        check("t6_overrun", 32'(overrun), 32'd0);
        check("t6_line_count", 32'(line_count), 32'd0);
        check("t6_busy", 32'(acq_busy), 32'd0);

        // First line after reset lands in bank 0 from idx 0.
        enable = 1'b1;
        start_line(1'b0, NS, 1'b1);
        drain(2000);
        check("t5_line_count", 32'(line_count), 32'd1);

        // Dropping enable mid-line still completes the line in bank 1.
        start_line(1'b1, NS, 1'b1);
        tick(100);
        enable = 1'b0;
        drain(2000);
        check("t6_enable_drop_lc", 32'(line_count), 32'd2);
        check("t6_enable_drop_bank", 32'(buf_bank), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aline_pingpong_writer.md
Name: aline_pingpong_writer

Overview:
- ADC-clock-domain writer for the A-line sample buffer. Captures NSAMPLES consecutive ADC samples after each rising sweep-trigger edge.
- Writes them into one half of a ping-pong dual-port RAM, then hands the full half to the readout side (sys clock domain) through a toggle handshake.
- Readout side returns each half through a release toggle. Writer never overwrites an unreleased half.

Parameters:
- NSAMPLES, 1170, samples per A-line.
- ADDR_W, 11, per-bank sample address width; NSAMPLES <= 2**ADDR_W.
- DATA_W, 14, ADC sample width.
- SYNC_STAGES, 2, flops in each async-input synchroniser.

Ports:
- ADC_data_out_clk  in  1  ADC output clock; sole clock.
- global_reset_n  in  1  async active-low reset.
- trigger_in  in  1  sweep trigger, async, active-high.
- enable  in  1  arm acquisition; sync to ADC_data_out_clk.
- adc_data  in  DATA_W  ADC channel A sample, valid every clock.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W+1  {bank, sample index}.
- wr_data  out  DATA_W  sample to write.
- buf_ready_toggle  out  1  toggles once per completed line.
- buf_bank  out  1  bank of the most recently completed line; stable while readout is pending.
- buf_release_toggle  in  1  from readout domain, async; each toggle frees the oldest full bank.
- acq_busy  out  1  high during CAPTURE.
- overrun  out  1  sticky: a trigger was dropped because the target bank was full.
- overrun_clr  in  1  sync pulse; clears overrun.
- line_count  out  16  completed lines, wraps at 65535->0.

Behaviour:
- Reset: global_reset_n is asynchronous, active-low; the clock is ADC_data_out_clk.
  - All outputs go to 0; FSM goes to IDLE.
  - wr_bank=0, rd_bank=0, bank_full=2'b00.
  - Synchroniser flops are cleared.
  - A reset mid-capture abandons the line and sends no ready toggle.
- Synchronisation:
  - trigger_in and buf_release_toggle each pass through SYNC_STAGES flops.
  - Trigger edge = synced & ~synced_d. Release event = synced ^ synced_d.
- Input pipeline: adc_data registered once into s_d. wr_data = s_d, so latency is 1 clock from adc_data to wr_data.
- FSM states:
  - IDLE
    - Trigger edge, enable=1, bank_full[wr_bank]=0: go to CAPTURE, idx=0.
    - Trigger edge, enable=1, bank_full[wr_bank]=1: set overrun, stay in IDLE.
    - enable=0: trigger edges ignored silently.
  - CAPTURE
    - Each cycle: wr_en=1, wr_addr={wr_bank, idx}, idx++.
    - First write is the cycle after the edge-detect cycle.
    - After the write with idx=NSAMPLES-1, go to HANDOFF.
    - Exactly NSAMPLES writes, contiguous, no gaps.
  - HANDOFF (1 cycle), then IDLE:
    - wr_en=0; bank_full[wr_bank]<=1; buf_bank<=wr_bank.
    - buf_ready_toggle flips; line_count++; wr_bank flips.
- Boundary rules:
  - Trigger edges during CAPTURE or HANDOFF are ignored; they are not counted as overrun.
  - enable falling during CAPTURE: the current line completes normally.
  - Release event: bank_full[rd_bank]<=0, rd_bank flips.
  - Release with bank_full=00 is ignored; the pointer does not move.
  - Release in the same cycle as HANDOFF marks the same bank: the set wins only if rd_bank != that bank. Both updates are applied independently per bit.
  - Trigger edge in the same cycle as a release of the target bank: the release is applied first, so the capture starts.
  - overrun_clr in the same cycle as a new overrun: overrun stays 1.
- acq_busy = (state==CAPTURE).

Decomposition:
- Shared package aline_pkg holds:
  - FSM state enum (IDLE, CAPTURE, HANDOFF).
  - Constants NSAMPLES_DEFAULT=1170, DATA_W=14, ADDR_W=11.
- One sub-module: sync_bit (SYNC_STAGES flop synchroniser with async reset). Instantiate it twice.

Test Plan:
- Reset, enable=1, one trigger pulse of 5 clocks, adc_data=ramp 0,1,2,… -> 1170 contiguous wr_en cycles, wr_addr 0x000..0x491, wr_data(k)=adc_data one clock earlier. Then buf_ready_toggle 0->1, buf_bank=0, line_count=1.
- Two triggers with no release -> bank0 then bank1 filled (wr_addr MSB 0 then 1). Third trigger -> no writes, overrun=1. overrun_clr -> overrun=0.
- After the previous test, toggle buf_release_toggle once -> bank0 free. Next trigger writes bank0; a further trigger with bank1 still full -> overrun.
- Trigger re-pulsed at idx=500 during CAPTURE -> ignored, exactly 1170 writes, one ready toggle, overrun=0.
- Assert global_reset_n low at idx=300 -> wr_en=0 immediately, outputs 0, no ready toggle. First trigger after reset writes bank0 from idx 0.
- enable=0 with 3 triggers -> no writes, overrun=0, line_count=0. enable dropped mid-line -> that line still completes.
